// File: rtl/knight_pkg.sv
// -----------------------------------------------------------------------------
// knight_pkg
//   Shared constants and types for the knight sprite address generator.
//   SPR_W / SPR_H     sprite frame size in pixels
//   N_WALK            number of walk frames (ROM frames 1..N_WALK, frame 0 = idle)
//   FRAME_DIV         vsync ticks per walk-frame advance
//   FRAME_WORDS       ROM words per frame
//   anim_state_t      animation FSM state
// -----------------------------------------------------------------------------
package knight_pkg;

  localparam int SPR_W       = 50;
  localparam int SPR_H       = 64;
  localparam int N_WALK      = 3;
  localparam int FRAME_DIV   = 6;
  localparam int FRAME_WORDS = SPR_W * SPR_H;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } anim_state_t;

endpackage

// File: rtl/knight_anim_fsm.sv
// -----------------------------------------------------------------------------
// knight_anim_fsm
//   Frame-rate side of the knight sprite: vsync synchroniser and end-of-pulse
//   tick, per-frame latches for the knight's position / facing, and the
//   idle/walk animation FSM with its frame divider.
//
// Ports
//   i_clk          pixel clock, all state on posedge
//   i_rst_n        async active-low reset
//   i_vs           VGA vsync, active low (asynchronous to nothing, but synced anyway)
//   i_knight_x/y   sprite box top-left corner (raw, may change any time)
//   i_moving       1 = knight walking
//   i_face_left    1 = draw mirrored
//   o_anim_frame   current ROM frame index, 0..N_WALK
//   o_knight_x_l   KnightX latched at the last tick
//   o_knight_y_l   KnightY latched at the last tick
//   o_face_left_l  face_left latched at the last tick
//   o_state        current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module knight_anim_fsm #(
  parameter int N_WALK    = knight_pkg::N_WALK,
  parameter int FRAME_DIV = knight_pkg::FRAME_DIV
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_vs,
  input  logic [9:0]              i_knight_x,
  input  logic [9:0]              i_knight_y,
  input  logic                    i_moving,
  input  logic                    i_face_left,
  output logic [1:0]              o_anim_frame,
  output logic [9:0]              o_knight_x_l,
  output logic [9:0]              o_knight_y_l,
  output logic                    o_face_left_l,
  output knight_pkg::anim_state_t o_state
);

  import knight_pkg::*;

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FRAME_DIV - 1);
  localparam logic [1:0]       LAST_WALK = 2'(N_WALK);

  // vsync synchroniser; reset to 1 (vsync inactive) so reset release never
  // looks like the end of a vsync pulse.
  logic r_vs_s1;
  logic r_vs_s2;
  logic r_vs_prev;
  logic w_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_s1   <= 1'b1;
      r_vs_s2   <= 1'b1;
      r_vs_prev <= 1'b1;
    end else begin
      r_vs_s1   <= i_vs;
      r_vs_s2   <= r_vs_s1;
      r_vs_prev <= r_vs_s2;
    end
  end

  // One-cycle pulse when the synchronised vsync goes 0 -> 1 (end of pulse).
  assign w_tick = r_vs_s2 & ~r_vs_prev;

  // Knight position / facing are only sampled on the tick so that a
  // mid-frame change cannot tear the sprite.
  logic [9:0] r_knight_x_l;
  logic [9:0] r_knight_y_l;
  logic       r_face_left_l;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_knight_x_l  <= '0;
      r_knight_y_l  <= '0;
      r_face_left_l <= 1'b0;
    end else if (w_tick) begin
      r_knight_x_l  <= i_knight_x;
      r_knight_y_l  <= i_knight_y;
      r_face_left_l <= i_face_left;
    end
  end

  // Animation FSM. The moving flag is consumed at the tick it is latched on,
  // so the FSM reacts to the same value the frame will be drawn with.
  anim_state_t      r_state;
  anim_state_t      w_state_nxt;
  logic [1:0]       r_frame;
  logic [1:0]       w_frame_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_div_nxt   = r_div;
    if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (i_moving) begin
            w_state_nxt = WALK;
            w_frame_nxt = 2'd1;
            w_div_nxt   = '0;
          end else begin
            w_frame_nxt = 2'd0;
          end
        end
        WALK: begin
          if (!i_moving) begin
            w_state_nxt = IDLE;
            w_frame_nxt = 2'd0;
            w_div_nxt   = '0;
          end else if (r_div == DIV_LAST) begin
            w_div_nxt   = '0;
            w_frame_nxt = (r_frame == LAST_WALK) ? 2'd1 : r_frame + 2'd1;
          end else begin
            w_div_nxt   = r_div + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_frame_nxt = 2'd0;
          w_div_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_frame <= 2'd0;
      r_div   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_frame <= w_frame_nxt;
      r_div   <= w_div_nxt;
    end
  end

  assign o_anim_frame  = r_frame;
  assign o_knight_x_l  = r_knight_x_l;
  assign o_knight_y_l  = r_knight_y_l;
  assign o_face_left_l = r_face_left_l;
  assign o_state       = r_state;

endmodule

// File: rtl/knight_sprite_addr_gen.sv
// -----------------------------------------------------------------------------
// knight_sprite_addr_gen
//   Address stage in front of the knight sprite ROM. Tests whether the beam is
//   inside the knight's box, mirrors the column for left-facing, and forms the
//   ROM address for the current animation frame. sprite_on is delayed so that
//   it lines up with the palette colour read back from the ROM.
//
// Ports
//   vga_clk      pixel clock, all state on posedge
//   reset_n      async active-low reset
//   vs           VGA vsync, active low
//   DrawX/DrawY  beam column / row
//   blank        1 = visible region
//   KnightX/Y    sprite box top-left corner
//   moving       1 = knight walking
//   face_left    1 = draw mirrored
//   rom_address  registered ROM address (ROM samples on negedge)
//   sprite_on    beam was inside the box, aligned with the palette output
//   anim_frame   current frame index, 0..N_WALK
//   o_dbg_state  animation FSM state (debug visibility)
//
// Timing: beam at cycle n -> rom_address valid after posedge n+1 -> ROM reads
// on the following negedge -> sprite_on valid after posedge n+2, i.e. in the
// cycle where downstream registers the palette colour.
// -----------------------------------------------------------------------------
module knight_sprite_addr_gen #(
  parameter int SPR_W     = knight_pkg::SPR_W,
  parameter int SPR_H     = knight_pkg::SPR_H,
  parameter int N_WALK    = knight_pkg::N_WALK,
  parameter int FRAME_DIV = knight_pkg::FRAME_DIV,
  parameter int ADDR_W    = 14
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic                    vs,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic                    blank,
  input  logic [9:0]              KnightX,
  input  logic [9:0]              KnightY,
  input  logic                    moving,
  input  logic                    face_left,
  output logic [ADDR_W-1:0]       rom_address,
  output logic                    sprite_on,
  output logic [1:0]              anim_frame,
  output knight_pkg::anim_state_t o_dbg_state
);

  import knight_pkg::*;

  localparam logic [10:0]       SPR_W_11    = 11'(SPR_W);
  localparam logic [10:0]       SPR_H_11    = 11'(SPR_H);
  localparam logic [10:0]       COL_MAX_11  = 11'(SPR_W - 1);
  localparam logic [ADDR_W-1:0] SPR_W_A     = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] FRAME_WDS_A = ADDR_W'(SPR_W * SPR_H);

  // ---------------------------------------------------------------------------
  // Frame-rate state (sync, latches, animation FSM)
  // ---------------------------------------------------------------------------
  logic [1:0]  w_anim_frame;
  logic [9:0]  w_knight_x_l;
  logic [9:0]  w_knight_y_l;
  logic        w_face_left_l;
  anim_state_t w_state;

  knight_anim_fsm #(
    .N_WALK    (N_WALK),
    .FRAME_DIV (FRAME_DIV)
  ) u_anim_fsm (
    .i_clk         (vga_clk),
    .i_rst_n       (reset_n),
    .i_vs          (vs),
    .i_knight_x    (KnightX),
    .i_knight_y    (KnightY),
    .i_moving      (moving),
    .i_face_left   (face_left),
    .o_anim_frame  (w_anim_frame),
    .o_knight_x_l  (w_knight_x_l),
    .o_knight_y_l  (w_knight_y_l),
    .o_face_left_l (w_face_left_l),
    .o_state       (w_state)
  );

  // ---------------------------------------------------------------------------
  // Stage 0: hit test and address arithmetic (combinational)
  // ---------------------------------------------------------------------------
  logic [10:0]       w_lx;
  logic [10:0]       w_ly;
  logic [10:0]       w_col;
  logic              w_hit;
  logic [ADDR_W-1:0] w_frame_ext;
  logic [ADDR_W-1:0] w_addr;

  // 11-bit differences: when the beam is left of / above the box the result
  // wraps to a large value, but the explicit >= checks reject those cases.
  assign w_lx = {1'b0, DrawX} - {1'b0, w_knight_x_l};
  assign w_ly = {1'b0, DrawY} - {1'b0, w_knight_y_l};

  // A box hanging off the right/bottom edge is simply never reached by the
  // beam there, so no wrap-around handling is needed.
  assign w_hit = blank
              && (DrawX >= w_knight_x_l) && (w_lx < SPR_W_11)
              && (DrawY >= w_knight_y_l) && (w_ly < SPR_H_11);

  assign w_col = w_face_left_l ? (COL_MAX_11 - w_lx) : w_lx;

  assign w_frame_ext = ADDR_W'(w_anim_frame);
  assign w_addr      = (w_frame_ext * FRAME_WDS_A)
                     + (ADDR_W'(w_ly) * SPR_W_A)
                     + ADDR_W'(w_col);

  // ---------------------------------------------------------------------------
  // Pipeline: address + hit at n+1, sprite_on at n+2
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_rom_address;
  logic              r_hit_d;
  logic              r_sprite_on;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_address <= '0;
      r_hit_d       <= 1'b0;
      r_sprite_on   <= 1'b0;
    end else begin
      // Off-box pixels read word 0 so the ROM never sees an out-of-range address.
      r_rom_address <= w_hit ? w_addr : '0;
      r_hit_d       <= w_hit;
      r_sprite_on   <= r_hit_d;
    end
  end

  assign rom_address = r_rom_address;
  assign sprite_on   = r_sprite_on;
  assign anim_frame  = w_anim_frame;
  assign o_dbg_state = w_state;

endmodule

// File: tb/tb_knight_sprite_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_knight_sprite_addr_gen
//   Directed bench for knight_sprite_addr_gen. Inputs change 1 time unit after
//   the rising edge; outputs are checked at the same point, after the edge has
//   settled. Expected values are hand-computed for SPR_W=50, SPR_H=64
//   (3200 words per frame), N_WALK=3, FRAME_DIV=6.
// -----------------------------------------------------------------------------
module tb_knight_sprite_addr_gen;

  import knight_pkg::*;

  localparam int ADDR_W = 14;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 vga_clk = ~vga_clk;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic              vs        = 1'b1;
  logic [9:0]        DrawX     = '0;
  logic [9:0]        DrawY     = '0;
  logic              blank     = 1'b0;
  logic [9:0]        KnightX   = '0;
  logic [9:0]        KnightY   = '0;
  logic              moving    = 1'b0;
  logic              face_left = 1'b0;
  logic [ADDR_W-1:0] rom_address;
  logic              sprite_on;
  logic [1:0]        anim_frame;
  anim_state_t       dbg_state;

  knight_sprite_addr_gen #(
    .ADDR_W (ADDR_W)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .vs          (vs),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .KnightX     (KnightX),
    .KnightY     (KnightY),
    .moving      (moving),
    .face_left   (face_left),
    .rom_address (rom_address),
    .sprite_on   (sprite_on),
    .anim_frame  (anim_frame),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Counters and checker
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // Low vsync pulse; afterwards enough cycles for sync (2), edge detect,
  // the latch/FSM update and one address-register update.
  task automatic vsync_pulse();
    vs = 1'b0;
    repeat (3) step();
    vs = 1'b1;
    repeat (4) step();
  endtask

  task automatic beam(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int exp_frame;

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_rom_address", 32'(rom_address), 32'd0);
    chk("rst_sprite_on",   32'(sprite_on),   32'd0);
    chk("rst_anim_frame",  32'(anim_frame),  32'd0);
    chk("rst_state",       32'(dbg_state),   32'(IDLE));
    reset_n = 1'b1;
    step();

    // Latches are 0 after reset -> box at (0,0). Beam (10,10) -> 10*50+10.
    blank = 1'b1;
    beam(10, 10);
    step();
    chk("pre_rst_rom_address", 32'(rom_address), 32'd510);
    step();
    chk("pre_rst_sprite_on", 32'(sprite_on), 32'd1);

    // Reset mid-line: outputs clear without waiting for a clock edge.
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_rom_address", 32'(rom_address), 32'd0);
    chk("mid_rst_sprite_on",   32'(sprite_on),   32'd0);
    chk("mid_rst_anim_frame",  32'(anim_frame),  32'd0);
    step();
    reset_n = 1'b1;
    step();

    // First tick with moving=0: stays idle, box latched at (100,200).
    KnightX   = 10'd100;
    KnightY   = 10'd200;
    moving    = 1'b0;
    face_left = 1'b0;
    blank     = 1'b0;
    vsync_pulse();
    chk("tick_idle_frame", 32'(anim_frame), 32'd0);
    chk("tick_idle_state", 32'(dbg_state),  32'(IDLE));

    // Top-left corner of the box.
    blank = 1'b1;
    beam(100, 200);
    step();
    chk("corner_rom_address", 32'(rom_address), 32'd0);
    step();
    chk("corner_sprite_on", 32'(sprite_on), 32'd1);

    // Bottom-right corner: 63*50 + 49.
    beam(149, 263);
    step();
    chk("br_rom_address", 32'(rom_address), 32'd3199);
    step();
    chk("br_sprite_on", 32'(sprite_on), 32'd1);

    // One past the right edge.
    beam(150, 263);
    step();
    chk("right_out_rom_address", 32'(rom_address), 32'd0);
    step();
    chk("right_out_sprite_on", 32'(sprite_on), 32'd0);

    // One past the bottom edge.
    beam(100, 264);
    step();
    step();
    chk("bottom_out_sprite_on", 32'(sprite_on), 32'd0);

    // One left of the box.
    beam(99, 200);
    step();
    step();
    chk("left_out_sprite_on", 32'(sprite_on), 32'd0);

    // Mirrored: column 0 on screen reads sprite column 49.
    face_left = 1'b1;
    vsync_pulse();
    beam(100, 200);
    step();
    chk("mirror_rom_address", 32'(rom_address), 32'd49);
    beam(149, 200);
    step();
    chk("mirror_right_rom_address", 32'(rom_address), 32'd0);
    beam(100, 200);
    step();

    // Walk animation over 25 ticks with beam held on the mirrored corner.
    moving = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      vsync_pulse();
      exp_frame = 1 + (((k - 1) / 6) % 3);
      chk($sformatf("walk_frame_t%0d", k), 32'(anim_frame), 32'(exp_frame));
      chk($sformatf("walk_state_t%0d", k), 32'(dbg_state), 32'(WALK));
      chk($sformatf("walk_rom_t%0d", k), 32'(rom_address), 32'(exp_frame * 3200 + 49));
    end
    // Spot checks of the hand-computed points.
    chk("walk_end_frame", 32'(anim_frame), 32'd2);
    chk("walk_end_rom",   32'(rom_address), 32'd6449);

    // Stop moving -> idle on the next tick.
    moving = 1'b0;
    vsync_pulse();
    chk("stop_frame", 32'(anim_frame), 32'd0);
    chk("stop_state", 32'(dbg_state),  32'(IDLE));
    chk("stop_rom",   32'(rom_address), 32'd49);

    // Mid-frame position change has no effect until the tick.
    face_left = 1'b0;
    vsync_pulse();
    KnightX = 10'd300;
    beam(120, 210);
    step();
    chk("old_box_rom", 32'(rom_address), 32'd520);
    beam(310, 210);
    step();
    chk("new_box_early_rom", 32'(rom_address), 32'd0);
    step();
    chk("new_box_early_on", 32'(sprite_on), 32'd0);
    vsync_pulse();
    chk("new_box_rom", 32'(rom_address), 32'd510);
    step();
    chk("new_box_on", 32'(sprite_on), 32'd1);
    beam(120, 210);
    step();
    chk("old_box_gone_rom", 32'(rom_address), 32'd0);

    // blank=0 inside the box.
    beam(310, 210);
    blank = 1'b0;
    step();
    chk("blank_rom", 32'(rom_address), 32'd0);
    step();
    chk("blank_on", 32'(sprite_on), 32'd0);
    blank = 1'b1;
    step();
    step();
    chk("unblank_on", 32'(sprite_on), 32'd1);

    // Box clipped at the right screen edge: no wrap to column 0.
    KnightX = 10'd1000;
    vsync_pulse();
    beam(1023, 200);
    step();
    chk("clip_edge_rom", 32'(rom_address), 32'd23);
    beam(5, 200);
    step();
    chk("clip_wrap_rom", 32'(rom_address), 32'd0);
    step();
    chk("clip_wrap_on", 32'(sprite_on), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case the sequence above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
